fsm_input_conditioner: RTL and testbench
========================================

# fsm_input_conditioner

Input conditioning stage that sits directly upstream of the control FSMs, such as the `testModule` FSM with inputs `in1..in3`. It takes asynchronous raw inputs from pins or other clock domains, synchronizes and debounces each one, and produces clean level signals for direct connection to FSM inputs. It also produces single-cycle rise and fall strobes for each channel. Every channel runs its own small debounce state machine.

## Interface
- `WIDTH`, 3: number of independent channels; one channel per FSM input.
- `SYNC_STAGES`, 2: synchronizer flop depth; legal values ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive identical synchronized samples required to accept a new level; legal values ≥1.

Ports (clock and reset first):
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `raw_in`  in  WIDTH  unsynchronized raw inputs.
- `enable`  in  1  debounce-advance enable; the synchronizer always runs.
- `cond_out`  out  WIDTH  debounced level per channel; connects to FSM inputs.
- `rise`  out  WIDTH  one-cycle pulse when `cond_out[i]` goes 0→1.
- `fall`  out  WIDTH  one-cycle pulse when `cond_out[i]` goes 1→0.
- `changed`  out  1  OR-reduction of `rise | fall`.

## Operation
**Synchronizer**
- Each channel has a chain of `SYNC_STAGES` flops. `s[i]` is the last stage of the chain.
- The chain is never gated by `enable`.

**Debounce FSM (per channel)**
- States: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
- Counter `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits, unsigned, and never wraps.
- STABLE_LO:
  - If `s=1`: when `DEBOUNCE_CYCLES==1`, go to STABLE_HI immediately; otherwise go to PEND_HI with `cnt=1`.
  - Otherwise hold.
- PEND_HI:
  - If `s=0`: go to STABLE_LO with `cnt=0`. The glitch is rejected and no output changes.
  - Else if `cnt+1==DEBOUNCE_CYCLES`: go to STABLE_HI with `cnt=0`.
  - Else `cnt++`.
- STABLE_HI and PEND_LO mirror the above with polarity inverted.
- `cond_out[i]` is 1 exactly in STABLE_HI and PEND_LO. It is registered, with no combinational path from `raw_in`.
- `rise[i]` and `fall[i]` are registered. They are asserted for exactly the one cycle in which `cond_out[i]` first shows its new value.

**Enable**
- When `enable=0`, every debounce FSM, counter and `cond_out` holds its value, and `rise`, `fall` and `changed` are forced to 0.
- When `enable` returns to 1, evaluation resumes from the held state using the current `s`.

**Channels**
- Channels are fully independent. Simultaneous transitions on several channels each produce their own `rise`/`fall`, and `changed` is asserted once for that cycle.

## Timing
**Reset state**
- All synchronizer flops are 0.
- All FSMs are in STABLE_LO with `cnt=0`.
- `cond_out`, `rise`, `fall` and `changed` are all 0.
- Assertion of reset is immediate (asynchronous). Release is sampled on the first rising edge where `reset_n=1`.

**Latency**
- Edge 1 is the first edge that captures a new `raw_in` level. If the level is held stable, `cond_out` and the strobe update at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- With default parameters this is edge 6, so the change is visible during cycle 6.

**Glitch rejection**
- A raw pulse that yields fewer than `DEBOUNCE_CYCLES` consecutive equal `s` samples causes no change on any output.

**Interaction with enable**
- Cycles with `enable=0` extend the latency by the number of gated cycles.
- Synchronizer samples taken during those gated cycles are not counted.

**Reset mid-operation**
- Reset asserted while a channel is pending discards the pending count, returns all channels to reset values, and produces no strobe.

**Strobes**
- `rise` and `fall` for the same channel are never asserted in the same cycle.
- Each strobe is never high for more than one consecutive cycle.

## Test plan
- **Reset:** hold `reset_n=0` with `raw_in=3'b111` toggling → all outputs stay 0. After release, with `raw_in=3'b001` stable and `enable=1` → `cond_out=3'b001` and `rise=3'b001` at edge 6, then `rise=0` at edge 7.
- **Glitch:** `raw_in[1]` high for 3 cycles, then low (defaults) → `cond_out[1]` stays 0 and `changed` is never asserted. `raw_in[1]` high for 4 cycles → `rise[1]` pulses once, and `fall[1]` pulses 4+ cycles after the release is synchronized.
- **Bounce:** `raw_in[2]` pattern 1,0,1,1,1,1 → exactly one `rise[2]`, at edge 2+4 counted from the last 0→1 transition.
- **Enable gating:** `raw_in[0]` rises, and `enable=0` for 5 cycles starting after edge 3 → the `cond_out[0]` transition is delayed by exactly 5 cycles, with no strobe while `enable=0`.
- **Simultaneous channels:** `raw_in` goes 000→111 → `rise=3'b111` and `changed=1` for one cycle at edge 6. Then `raw_in` goes 111→010 → `fall=3'b101` for one cycle.
- **Reset mid-pending:** `raw_in[0]=1` for 4 cycles, then pulse `reset_n` low asynchronously between edges → outputs go 0 immediately. The debounce restarts, giving the full 6-edge latency after release.

Source files
------------

// File: rtl/fsm_input_conditioner.sv
// Input conditioner for control-FSM inputs: each raw channel passes through a
// flop synchronizer and a four-state debounce machine. The result is a clean
// level per channel plus single-cycle rise and fall strobes. All outputs come
// straight from flops, so there is no combinational path from raw_in.
module fsm_input_conditioner #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             enable,
    output logic [WIDTH-1:0] cond_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // The last pending sample that completes a debounce run has cnt == DEBOUNCE_CYCLES-1.
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    // A single-sample debounce accepts a new level straight from the stable states.
    localparam logic          DEB_ONE   = (DEBOUNCE_CYCLES == 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_PEND_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_PEND_LO   = 2'd3
    } deb_state_t;

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] s_s;
    deb_state_t       state_r [WIDTH];
    logic [CW-1:0]    cnt_r   [WIDTH];
    logic [WIDTH-1:0] cond_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic             changed_r;
    logic [WIDTH-1:0] accept_hi_s;
    logic [WIDTH-1:0] accept_lo_s;

    assign s_s      = sync_r[SYNC_STAGES-1];
    assign cond_out = cond_r;
    assign rise     = rise_r;
    assign fall     = fall_r;
    assign changed  = changed_r;

    // Synchronizer chain; it always runs, independent of enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Detect the edge on which each channel accepts a new level this cycle.
    always_comb begin
        accept_hi_s = '0;
        accept_lo_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (enable) begin
                case (state_r[i])
                    ST_STABLE_LO: accept_hi_s[i] = s_s[i] & DEB_ONE;
                    ST_PEND_HI:   accept_hi_s[i] = s_s[i] & (cnt_r[i] == DEB_LAST);
                    ST_STABLE_HI: accept_lo_s[i] = ~s_s[i] & DEB_ONE;
                    ST_PEND_LO:   accept_lo_s[i] = ~s_s[i] & (cnt_r[i] == DEB_LAST);
                    default: begin
                        accept_hi_s[i] = 1'b0;
                        accept_lo_s[i] = 1'b0;
                    end
                endcase
            end else begin
                accept_hi_s[i] = 1'b0;
                accept_lo_s[i] = 1'b0;
            end
        end
    end

    // Per-channel debounce FSMs with registered level, strobes and change flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_r[i] <= ST_STABLE_LO;
                cnt_r[i]   <= CNT_ZERO;
            end
            cond_r    <= '0;
            rise_r    <= '0;
            fall_r    <= '0;
            changed_r <= 1'b0;
        end else if (!enable) begin
            // Freeze debounce state; strobes must not linger while gated.
            rise_r    <= '0;
            fall_r    <= '0;
            changed_r <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case (state_r[i])
                    ST_STABLE_LO: begin
                        if (s_s[i]) begin
                            if (accept_hi_s[i]) begin
                                state_r[i] <= ST_STABLE_HI;
                                cnt_r[i]   <= CNT_ZERO;
                            end else begin
                                state_r[i] <= ST_PEND_HI;
                                cnt_r[i]   <= CNT_ONE;
                            end
                        end
                    end
                    ST_PEND_HI: begin
                        if (!s_s[i]) begin
                            state_r[i] <= ST_STABLE_LO;
                            cnt_r[i]   <= CNT_ZERO;
                        end else if (accept_hi_s[i]) begin
                            state_r[i] <= ST_STABLE_HI;
                            cnt_r[i]   <= CNT_ZERO;
                        end else begin
                            cnt_r[i]   <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    ST_STABLE_HI: begin
                        if (!s_s[i]) begin
                            if (accept_lo_s[i]) begin
                                state_r[i] <= ST_STABLE_LO;
                                cnt_r[i]   <= CNT_ZERO;
                            end else begin
                                state_r[i] <= ST_PEND_LO;
                                cnt_r[i]   <= CNT_ONE;
                            end
                        end
                    end
                    ST_PEND_LO: begin
                        if (s_s[i]) begin
                            state_r[i] <= ST_STABLE_HI;
                            cnt_r[i]   <= CNT_ZERO;
                        end else if (accept_lo_s[i]) begin
                            state_r[i] <= ST_STABLE_LO;
                            cnt_r[i]   <= CNT_ZERO;
                        end else begin
                            cnt_r[i]   <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r[i] <= ST_STABLE_LO;
                        cnt_r[i]   <= CNT_ZERO;
                    end
                endcase
            end
            cond_r    <= (cond_r | accept_hi_s) & ~accept_lo_s;
            rise_r    <= accept_hi_s;
            fall_r    <= accept_lo_s;
            changed_r <= |(accept_hi_s | accept_lo_s);
        end
    end

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Bench for fsm_input_conditioner: a cycle model of synchronizer plus run-length
// debounce pushes expected outputs on each clock edge; a monitor pops and
// compares on the falling edge. Directed checks cover the scenario specifics.
module tb_fsm_input_conditioner;

    localparam int W = 3;
    localparam int S = 2;
    localparam int D = 4;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic         enable;
    logic [W-1:0] cond_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3*W:0] sb_q [$];

    logic [W-1:0] m_sync [S];
    logic [W-1:0] m_level;
    int           m_run [W];

    int cnt_a, cnt_b, idx_a;
    logic [9:0] bpat;

    fsm_input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock(clock), .reset_n(reset_n), .raw_in(raw_in), .enable(enable),
        .cond_out(cond_out), .rise(rise), .fall(fall), .changed(changed)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < S; k++) m_sync[k] = '0;
        m_level = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    // Model one rising edge: debounce sees the old synchronizer output, then the chain shifts.
    task automatic model_edge();
        logic [W-1:0] s_now;
        logic [W-1:0] r;
        logic [W-1:0] f;
        r = '0;
        f = '0;
        if (!reset_n) begin
            model_reset();
        end else begin
            s_now = m_sync[S-1];
            if (enable) begin
                for (int i = 0; i < W; i++) begin
                    if (s_now[i] != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == D) begin
                            m_level[i] = s_now[i];
                            m_run[i]   = 0;
                            if (s_now[i]) r[i] = 1'b1;
                            else          f[i] = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            for (int k = S - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = raw_in;
        end
        sb_q.push_back({m_level, r, f, |(r | f)});
    endtask

    // One clock cycle of stimulus; optional async reset pulse between edges.
    task automatic step(input logic rst, input logic [W-1:0] raw, input logic en, input logic pulse);
        @(negedge clock);
        reset_n = rst;
        raw_in  = raw;
        enable  = en;
        if (pulse) begin
            #1 reset_n = 1'b0;
            #1 check_eq("rst_async", {22'd0, cond_out, rise, fall, changed}, 32'd0);
            #1 reset_n = 1'b1;
            model_reset();
        end
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // Scoreboard monitor: compare outputs away from the active edge.
    always @(negedge clock) begin
        logic [3*W:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("sb", {22'd0, cond_out, rise, fall, changed}, {22'd0, e});
        end
    end

    initial begin
        reset_n = 1'b0;
        raw_in  = '0;
        enable  = 1'b1;
        model_reset();

        // Reset hold with toggling inputs, then release with raw_in=001
        for (int k = 0; k < 4; k++) begin
            step(1'b0, (k % 2 == 0) ? 3'b111 : 3'b000, 1'b1, 1'b0);
            check_eq("rst_hold", {22'd0, cond_out, rise, fall, changed}, 32'd0);
        end
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 3'b001, 1'b1, 1'b0);
            if (k == 5) check_eq("rel_cond5", {29'd0, cond_out}, 32'd0);
            if (k == 6) begin
                check_eq("rel_cond6", {29'd0, cond_out}, 32'd1);
                check_eq("rel_rise6", {29'd0, rise}, 32'd1);
            end
            if (k == 7) check_eq("rel_rise7", {29'd0, rise}, 32'd0);
        end

        // Glitch of three cycles on channel 1 is rejected
        cnt_a = 0;
        for (int k = 0; k < 11; k++) begin
            step(1'b1, (k < 3) ? 3'b011 : 3'b001, 1'b1, 1'b0);
            if (changed) cnt_a++;
        end
        check_eq("glitch_chg", cnt_a, 32'd0);
        check_eq("glitch_cond", {29'd0, cond_out}, 32'd1);

        // Four-cycle pulse on channel 1 passes, then falls
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, (k < 4) ? 3'b011 : 3'b001, 1'b1, 1'b0);
            if (rise[1]) cnt_a++;
            if (fall[1]) cnt_b++;
        end
        check_eq("pulse4_rise", cnt_a, 32'd1);
        check_eq("pulse4_fall", cnt_b, 32'd1);

        // Bounce on channel 2: 1,0,1,1,1,...
        bpat  = 10'b1111111101;
        cnt_a = 0;
        idx_a = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, {bpat[k], 1'b0, 1'b1}, 1'b1, 1'b0);
            if (rise[2]) begin
                cnt_a++;
                idx_a = k + 1;
            end
        end
        check_eq("bounce_cnt", cnt_a, 32'd1);
        check_eq("bounce_edge", idx_a, 32'd8);

        // Enable gating delays channel 0 by the gated cycles
        for (int k = 0; k < 8; k++) step(1'b1, 3'b000, 1'b1, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        idx_a = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 3'b001, (k >= 3 && k < 8) ? 1'b0 : 1'b1, 1'b0);
            if (rise[0]) begin
                cnt_a++;
                idx_a = k + 1;
            end
            if (!enable && (changed || rise != 3'b000)) cnt_b++;
        end
        check_eq("en_rise_cnt", cnt_a, 32'd1);
        check_eq("en_rise_edge", idx_a, 32'd11);
        check_eq("en_gated_strobe", cnt_b, 32'd0);

        // Simultaneous channels: 000 -> 111 -> 010
        for (int k = 0; k < 8; k++) step(1'b1, 3'b000, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 3'b111, 1'b1, 1'b0);
            if (k == 6) check_eq("sim_rise6", {28'd0, rise, changed}, 32'hF);
            if (k == 7) check_eq("sim_rise7", {28'd0, rise, changed}, 32'h0);
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 3'b010, 1'b1, 1'b0);
            if (k == 6) check_eq("sim_fall6", {28'd0, fall, changed}, 32'hB);
            if (k == 7) check_eq("sim_fall7", {28'd0, fall, changed}, 32'h0);
        end

        // Reset mid-pending on channel 0 restarts full latency
        for (int k = 0; k < 8; k++) step(1'b1, 3'b100, 1'b1, 1'b0);
        check_eq("pre_rst_cond", {29'd0, cond_out}, 32'd4);
        for (int k = 0; k < 4; k++) step(1'b1, 3'b101, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 3'b101, 1'b1, (k == 1) ? 1'b1 : 1'b0);
            if (k == 5) check_eq("mid_cond5", {29'd0, cond_out}, 32'd0);
            if (k == 6) begin
                check_eq("mid_cond6", {29'd0, cond_out}, 32'd5);
                check_eq("mid_rise6", {29'd0, rise}, 32'd5);
            end
        end

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
